// File: rtl/l1_cache_ctrl.sv
// L1 data-cache miss controller: hit check, dirty-victim writeback, block refill,
// line install and CPU completion, one CPU access at a time.
module l1_cache_ctrl #(
  parameter int ADDR_WIDTH      = 32,
  parameter int WORDS_PER_BLOCK = 4,
  parameter int OFFSET_WIDTH    = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    cpu_rden,
  input  logic                    cpu_wren,
  input  logic [ADDR_WIDTH-1:0]   cpu_addr,
  output logic                    cpu_stall,
  output logic                    cpu_done,
  input  logic                    lookup_hit,
  input  logic                    victim_dirty,
  input  logic [ADDR_WIDTH-1:0]   victim_addr,
  output logic                    cache_wr_word,
  output logic [OFFSET_WIDTH-1:0] cache_word_sel,
  output logic                    cache_set_valid,
  output logic                    cache_cpu_wr,
  output logic                    mem_req,
  output logic                    mem_we,
  output logic [ADDR_WIDTH-1:0]   mem_addr,
  input  logic                    mem_ack
);

  typedef enum logic [2:0] {IDLE, WB, REFILL, INSTALL, RESP} state_t;

  localparam logic [OFFSET_WIDTH-1:0] LAST_WORD  = OFFSET_WIDTH'(WORDS_PER_BLOCK - 1);
  localparam logic [ADDR_WIDTH-1:0]   BLOCK_MASK =
    ~ADDR_WIDTH'((64'd1 << (OFFSET_WIDTH + 2)) - 64'd1);

  state_t                  state, state_next;
  logic [OFFSET_WIDTH-1:0] cnt, cnt_next;
  logic [ADDR_WIDTH-1:0]   req_addr, vict_addr;
  logic                    is_write;
  logic                    request;
  logic [ADDR_WIDTH-1:0]   word_off;

  assign request  = cpu_rden | cpu_wren;
  assign word_off = ADDR_WIDTH'({cnt, 2'b00});

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      req_addr  <= '0;
      vict_addr <= '0;
      is_write  <= 1'b0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
      if (state == IDLE && request) begin
        req_addr  <= cpu_addr;
        vict_addr <= victim_addr;
        is_write  <= cpu_wren;
      end
    end
  end

  always_comb begin
    state_next      = state;
    cnt_next        = cnt;
    cpu_done        = 1'b0;
    cache_wr_word   = 1'b0;
    cache_word_sel  = '0;
    cache_set_valid = 1'b0;
    cache_cpu_wr    = 1'b0;
    mem_req         = 1'b0;
    mem_we          = 1'b0;
    mem_addr        = '0;
    unique case (state)
      IDLE: begin
        // Hit/dirty are only trusted in the request cycle; later phases use latched state
        if (request) begin
          if (lookup_hit)        state_next = RESP;
          else if (victim_dirty) state_next = WB;
          else                   state_next = REFILL;
        end
      end
      WB: begin
        mem_req        = 1'b1;
        mem_we         = 1'b1;
        mem_addr       = vict_addr + word_off;
        cache_word_sel = cnt;
        if (mem_ack) begin
          if (cnt == LAST_WORD) begin
            cnt_next   = '0;
            state_next = REFILL;
          end else begin
            cnt_next = cnt + OFFSET_WIDTH'(1);
          end
        end
      end
      REFILL: begin
        mem_req        = 1'b1;
        mem_addr       = (req_addr & BLOCK_MASK) + word_off;
        cache_word_sel = cnt;
        if (mem_ack) begin
          cache_wr_word = 1'b1;
          if (cnt == LAST_WORD) begin
            cnt_next   = '0;
            state_next = INSTALL;
          end else begin
            cnt_next = cnt + OFFSET_WIDTH'(1);
          end
        end
      end
      INSTALL: begin
        cache_set_valid = 1'b1;
        state_next      = RESP;
      end
      RESP: begin
        cpu_done     = 1'b1;
        cache_cpu_wr = is_write;
        state_next   = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign cpu_stall = request & ~cpu_done;

endmodule

// File: tb/tb_l1_cache_ctrl.sv
// Bench for l1_cache_ctrl: table-driven and random accesses checked cycle by cycle
// against a transaction-level model of the expected memory traffic and strobes.
module tb_l1_cache_ctrl;
  localparam int AW  = 32;
  localparam int WPB = 4;
  localparam int OW  = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          cpu_rden, cpu_wren;
  logic [AW-1:0] cpu_addr;
  logic          cpu_stall, cpu_done;
  logic          lookup_hit, victim_dirty;
  logic [AW-1:0] victim_addr;
  logic          cache_wr_word;
  logic [OW-1:0] cache_word_sel;
  logic          cache_set_valid, cache_cpu_wr;
  logic          mem_req, mem_we;
  logic [AW-1:0] mem_addr;
  logic          mem_ack;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  l1_cache_ctrl #(.ADDR_WIDTH(AW), .WORDS_PER_BLOCK(WPB), .OFFSET_WIDTH(OW)) dut (
    .clk(clk), .rst(rst),
    .cpu_rden(cpu_rden), .cpu_wren(cpu_wren), .cpu_addr(cpu_addr),
    .cpu_stall(cpu_stall), .cpu_done(cpu_done),
    .lookup_hit(lookup_hit), .victim_dirty(victim_dirty), .victim_addr(victim_addr),
    .cache_wr_word(cache_wr_word), .cache_word_sel(cache_word_sel),
    .cache_set_valid(cache_set_valid), .cache_cpu_wr(cache_cpu_wr),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_ack(mem_ack)
  );

  typedef struct {
    logic        we;
    logic [31:0] addr;
    int          sel;
  } op_t;

  typedef struct {
    logic        rd;
    logic        wr;
    logic [31:0] addr;
    logic        hit;
    logic        dirty;
    logic [31:0] vaddr;
    int          lat;
    bit          stray;
    int          abort;
    int          exp_done;
    logic        exp_cpu_wr;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_mem_req"}, mem_req, 0);
    check({tag, "_mem_we"}, mem_we, 0);
    check({tag, "_mem_addr"}, mem_addr, 0);
    check({tag, "_wr_word"}, cache_wr_word, 0);
    check({tag, "_word_sel"}, cache_word_sel, 0);
    check({tag, "_set_valid"}, cache_set_valid, 0);
    check({tag, "_cpu_wr"}, cache_cpu_wr, 0);
    check({tag, "_done"}, cpu_done, 0);
    check({tag, "_stall"}, cpu_stall, 0);
  endtask

  // One CPU access; expected traffic is derived from the block-level rules, then
  // consumed in order as the bench's memory acknowledges each word.
  task automatic run_txn(input vec_t v);
    op_t         q[$];
    logic [31:0] blk;
    int          idx, last_ack, pops, wait_n, dut_done_idx;
    logic        wr_at_done;
    bit          fin, exp_done, exp_sv, exp_mreq;
    if (!v.hit) begin
      if (v.dirty)
        for (int i = 0; i < WPB; i++) q.push_back('{1'b1, v.vaddr + 32'(4 * i), i});
      blk = v.addr & ~32'(4 * WPB - 1);
      for (int i = 0; i < WPB; i++) q.push_back('{1'b0, blk + 32'(4 * i), i});
    end
    @(posedge clk); #1;
    cpu_rden = v.rd; cpu_wren = v.wr; cpu_addr = v.addr;
    lookup_hit = v.hit; victim_dirty = v.dirty; victim_addr = v.vaddr;
    mem_ack = v.stray;
    idx = 0; last_ack = -10; pops = 0; wait_n = 0; fin = 0;
    dut_done_idx = -1; wr_at_done = 1'bx;
    while (!fin) begin
      @(negedge clk);
      exp_mreq = (idx >= 1) && (q.size() > 0);
      check("mem_req", mem_req, exp_mreq);
      if (mem_req && q.size() > 0) begin
        check("mem_we", mem_we, q[0].we);
        check("mem_addr", mem_addr, q[0].addr);
        check("word_sel", cache_word_sel, q[0].sel);
        check("wr_word", cache_wr_word, mem_ack && !q[0].we);
      end else begin
        check("wr_word_idle", cache_wr_word, 0);
      end
      exp_done = (idx >= 1) && (v.hit ? (idx == 1) : (q.size() == 0 && idx == last_ack + 2));
      exp_sv   = !v.hit && q.size() == 0 && idx == last_ack + 1;
      check("cpu_done", cpu_done, exp_done);
      check("cpu_wr", cache_cpu_wr, exp_done && v.wr);
      check("set_valid", cache_set_valid, exp_sv);
      check("cpu_stall", cpu_stall, !exp_done);
      if (cpu_done && dut_done_idx < 0) begin
        dut_done_idx = idx;
        wr_at_done   = cache_cpu_wr;
      end
      if (v.abort >= 0 && pops == v.abort && mem_req && !mem_ack) begin
        #2;
        rst = 1'b1; cpu_rden = 1'b0; cpu_wren = 1'b0; mem_ack = 1'b0;
        #1;
        check_idle_outputs("async_rst");
        @(posedge clk); #2;
        rst = 1'b0;
        return;
      end
      if (mem_req && mem_ack && q.size() > 0) begin
        void'(q.pop_front());
        pops++;
        last_ack = idx;
      end
      if (exp_done) fin = 1;
      if (!fin && idx >= 200) begin
        checks++; errors++;
        $display("FAIL timeout: access 0x%0h not completed, %0d words left", v.addr, q.size());
        fin = 1;
      end
      if (mem_req && !mem_ack) wait_n++;
      else wait_n = 0;
      @(posedge clk); #1;
      if (fin) begin
        cpu_rden = 1'b0; cpu_wren = 1'b0; mem_ack = 1'b0;
      end else begin
        mem_ack      = (wait_n >= v.lat);
        cpu_addr     = $urandom;
        lookup_hit   = 1'($urandom);
        victim_dirty = 1'($urandom);
        victim_addr  = $urandom;
      end
      idx++;
    end
    if (v.exp_done >= 0) check("done_cycle", dut_done_idx, v.exp_done);
    check("cpu_wr_at_done", wr_at_done, v.exp_cpu_wr);
  endtask

  vec_t tbl[10];
  vec_t rv;

  initial begin
    //           rd wr addr           hit dirty vaddr          lat stray abort done wr
    tbl[0] = '{1, 0, 32'h0000_0100, 1, 0, 32'h0000_0000, 1, 0, -1,  1, 0};
    tbl[1] = '{1, 0, 32'h0000_0124, 0, 0, 32'h0000_0A00, 2, 0, -1, 14, 0};
    tbl[2] = '{0, 1, 32'h0000_0208, 0, 1, 32'h0000_1200, 1, 0, -1, 18, 1};
    tbl[3] = '{0, 1, 32'h0000_0040, 1, 1, 32'h0000_0700, 1, 0, -1,  1, 1};
    tbl[4] = '{1, 0, 32'h0000_02F4, 0, 0, 32'h0000_0000, 1, 0,  2, -1, 0};
    tbl[5] = '{1, 0, 32'h0000_0300, 0, 0, 32'h0000_0000, 1, 0, -1, 10, 0};
    tbl[6] = '{1, 1, 32'h0000_0500, 1, 0, 32'h0000_0000, 1, 1, -1,  1, 1};
    tbl[7] = '{1, 0, 32'hFFFF_FFF4, 0, 1, 32'hFFFF_FFF8, 3, 0, -1, 34, 0};
    tbl[8] = '{0, 1, 32'h0000_0044, 0, 1, 32'h0000_0800, 1, 0,  1, -1, 0};
    tbl[9] = '{0, 1, 32'h0000_001C, 0, 0, 32'h0000_0C40, 2, 1, -1, 14, 1};

    rst = 1'b1;
    cpu_rden = 1'b0; cpu_wren = 1'b0; cpu_addr = '0;
    lookup_hit = 1'b0; victim_dirty = 1'b0; victim_addr = '0; mem_ack = 1'b0;
    #3;
    check_idle_outputs("por");
    @(posedge clk); #2;
    rst = 1'b0;

    // A stray acknowledge with no request must not move the controller
    @(posedge clk); #1;
    mem_ack = 1'b1;
    @(negedge clk);
    check_idle_outputs("stray_ack");
    @(posedge clk); #1;
    mem_ack = 1'b0;
    @(negedge clk);
    check_idle_outputs("after_stray");

    for (int i = 0; i < 10; i++) run_txn(tbl[i]);

    for (int i = 0; i < 40; i++) begin
      rv.rd    = 1'($urandom);
      rv.wr    = 1'($urandom);
      if (!rv.rd && !rv.wr) rv.rd = 1'b1;
      rv.addr  = $urandom;
      rv.hit   = 1'($urandom);
      rv.dirty = 1'($urandom);
      rv.vaddr = $urandom & ~32'hF;
      rv.lat   = int'($urandom_range(1, 3));
      rv.stray = 1'($urandom);
      rv.abort = -1;
      rv.exp_done   = rv.hit ? 1 : ((rv.dirty ? 2 * WPB : WPB) * (rv.lat + 1) + 2);
      rv.exp_cpu_wr = rv.wr;
      run_txn(rv);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule

// File: doc/l1_cache_ctrl.md
Name: l1_cache_ctrl

Overview:
Miss-handling controller for the L1 data cache. It accepts one CPU read or write at a time and checks the hit result from the cache datapath. On a miss it writes back the dirty victim block word by word to memory, refills the requested block word by word, then installs the line. It drives the datapath strobes and holds the CPU stalled until the access completes.

Parameters:
ADDR_WIDTH, 32, byte-address width of CPU and memory ports
WORDS_PER_BLOCK, 4, 32-bit words per cache block (power of 2, >=2)
OFFSET_WIDTH, 2, log2(WORDS_PER_BLOCK); width of the word-select field

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-high reset
cpu_rden  in  1  CPU read request
cpu_wren  in  1  CPU write request; wins over cpu_rden if both are high
cpu_addr  in  ADDR_WIDTH  CPU byte address
cpu_stall  out  1  high while a request is pending and not yet completed
cpu_done  out  1  one-cycle completion pulse
lookup_hit  in  1  datapath hit result for cpu_addr (combinational)
victim_dirty  in  1  indexed line is valid and dirty
victim_addr  in  ADDR_WIDTH  block base byte address of the indexed line
cache_wr_word  out  1  write the memory read word into the line
cache_word_sel  out  OFFSET_WIDTH  word index for cache_wr_word and writeback data select
cache_set_valid  out  1  install tag, set valid, clear dirty
cache_cpu_wr  out  1  apply CPU store data, set dirty
mem_req  out  1  memory word request
mem_we  out  1  1 = write (writeback), 0 = read (refill)
mem_addr  out  ADDR_WIDTH  memory word byte address
mem_ack  in  1  memory accepted or returned the current word

Behaviour:
- Reset (asynchronous, any state): state=IDLE, word counter=0, latched addresses=0. All registered outputs are 0; cpu_stall follows its equation. Any in-flight memory transaction is abandoned.
- States: IDLE, WB, REFILL, INSTALL, RESP.
- IDLE: a request is (cpu_rden|cpu_wren).
  - On a request, latch cpu_addr, victim_addr and is_write.
  - lookup_hit=1: go to RESP.
  - Miss with victim_dirty=1: go to WB.
  - Miss with victim_dirty=0: go to REFILL.
- WB: mem_req=1, mem_we=1, mem_addr = latched victim base + 4*cnt, cache_word_sel=cnt. On mem_ack, cnt++. On the ack with cnt=WORDS_PER_BLOCK-1, set cnt=0 and go to REFILL.
- REFILL: mem_req=1, mem_we=0, mem_addr = latched block base (cpu_addr with its low OFFSET_WIDTH+2 bits cleared) + 4*cnt.
  - On mem_ack: cache_wr_word=1 and cache_word_sel=cnt in the same cycle, then cnt++.
  - On the ack for the last word, set cnt=0 and go to INSTALL.
- INSTALL: cache_set_valid=1 for one cycle, then go to RESP.
- RESP: cpu_done=1 for one cycle. cache_cpu_wr=is_write in the same cycle. Return to IDLE.
- Hit latency: request in IDLE at cycle N, cpu_done at cycle N+1.
- Clean-miss latency: 1 (IDLE) + refill cycles + 1 (INSTALL) + 1 (RESP).
- mem_req stays high, and mem_addr/mem_we stay stable, until mem_ack. mem_ack outside WB/REFILL is ignored.
- cpu_stall = (rden|wren) & ~cpu_done, combinational. It is high in the request cycle, including hits.
- cpu_addr and lookup_hit changes while not in IDLE are ignored; only the latched values are used.
- A request held high after cpu_done is treated as a new request in the next IDLE cycle.
- Address arithmetic wraps modulo 2^ADDR_WIDTH. cnt wraps only via the explicit reset to 0.

Test Plan:
1. Assert rst asynchronously mid-cycle -> all registered outputs 0 immediately; mem_req=0; with no request, cpu_stall=0.
2. Read 0x100 with lookup_hit=1 -> cpu_done=1 exactly one cycle later; cache_cpu_wr=0; mem_req never asserted.
3. Clean read miss 0x124, mem_ack two cycles after each request ->
   - reads at mem_addr 0x120, 0x124, 0x128, 0x12C with mem_we=0;
   - cache_wr_word with sel 0..3;
   - one cache_set_valid cycle, then cpu_done.
4. Dirty write miss 0x208, victim_addr=0x1200 ->
   - writes at 0x1200, 0x1204, 0x1208, 0x120C with mem_we=1;
   - then reads at 0x200..0x20C;
   - then INSTALL, then RESP with cpu_done=1 and cache_cpu_wr=1.
5. rst during REFILL after 2 acks -> outputs clear at once. A following miss to 0x300 starts at mem_addr 0x300 (cnt=0).
6. Assert mem_ack in IDLE, and issue rden=wren=1 on a hit -> no state change from the stray ack; the access is handled as a write (cache_cpu_wr=1 in RESP).
